sad_frame_writer: RTL

SAD_FRAME_WRITER -- requirements
Module: sad_frame_writer

---
 rtl/sad_frame_writer.sv | 105 ++++++++++
 1 files changed

// File: rtl/sad_frame_writer.sv
// Frame writer: walks a rows x cols frame of pixel words into memory at
// baseAddr with a per-row byte stride, issuing one registered write per word.
module sad_frame_writer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [7:0]        frameCols,
  input  logic [7:0]        frameRows,
  input  logic [DATA_W-1:0] inData,
  input  logic              inValid,
  output logic              inReady,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWrData,
  output logic              memWrEn,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic [7:0]        col;
  logic [7:0]        row;
  logic [7:0]        cols_q;
  logic [7:0]        rows_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] cur_addr;
  logic              accept;
  logic              last_col;
  logic              last_row;

  // Handshake: a word transfers on any rising edge where inValid && inReady;
  // inReady depends only on state, so the source may hold inValid freely.
  assign inReady   = (state == WRITE);
  assign accept    = inValid && inReady;
  assign busy      = (state == WRITE) || (state == DONE);
  assign done      = (state == DONE);
  assign dbg_state = state;
  assign last_col  = (col == cols_q - 8'd1);
  assign last_row  = (row == rows_q - 8'd1);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      cols_q    <= '0;
      rows_q    <= '0;
      stride_q  <= '0;
      row_base  <= '0;
      cur_addr  <= '0;
      memAddr   <= '0;
      memWrData <= '0;
      memWrEn   <= 1'b0;
    end else begin
      memWrEn <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cols_q   <= frameCols;
            rows_q   <= frameRows;
            stride_q <= stride;
            row_base <= baseAddr;
            cur_addr <= baseAddr;
            col      <= '0;
            row      <= '0;
            // An empty frame still produces its done pulse, just without writes.
            if (frameCols == 8'd0 || frameRows == 8'd0) state <= DONE;
            else                                        state <= WRITE;
          end
        end
        WRITE: begin
          if (accept) begin
            memAddr   <= cur_addr;
            memWrData <= inData;
            memWrEn   <= 1'b1;
            if (!last_col) begin
              col      <= col + 8'd1;
              cur_addr <= cur_addr + ADDR_W'(4);
            end else if (!last_row) begin
              col      <= '0;
              row      <= row + 8'd1;
              row_base <= row_base + stride_q;
              cur_addr <= row_base + stride_q;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
